sync_sp_ram_be_init: RTL and testbench

- Parametrised synchronous single-port RAM with per-byte write enables. Successor to the fixed 256x64 byte-enable SRAM wrappers.
- Generalised in width and depth, with an optional output pipeline register and a read-valid strobe.
- Built-in zero-fill (init) engine clears the whole array after reset or on request.
- Sits under cache/TLB data arrays. Clients must not access it until Ready_SO is high.

---
 rtl/sync_sp_ram_be_init.sv | 130 +++++++++++++
 tb/tb_sync_sp_ram_be_init.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_sp_ram_be_init.sv
// Synchronous single-port RAM with per-byte write enables, an optional output
// register and a built-in zero-fill engine that clears the array after reset or on request.
module sync_sp_ram_be_init #(
  parameter int  DATA_WIDTH = 64,
  parameter int  DEPTH      = 256,
  parameter bit  OUT_REG    = 1'b0,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    Init_SI,
  output logic                    Ready_SO,
  input  logic                    CSel_SI,
  input  logic                    WrEn_SI,
  input  logic [DATA_WIDTH/8-1:0] BEn_SI,
  input  logic [ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [DATA_WIDTH-1:0]   WrData_DI,
  output logic [DATA_WIDTH-1:0]   RdData_DO,
  output logic                    RdValid_SO
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NUM_BYTES-1:0]    mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_acc;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   rd_data_p0;
  logic                    vld_p0;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The fill engine owns the write port while in INIT; client requests are ignored.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = Addr_DI;
    mem_be    = BEn_SI;
    mem_wdata = WrData_DI;
    rd_acc    = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_be    = '1;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) state_d = READY;
      end
      READY: begin
        if (Init_SI) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (CSel_SI) begin
          if (WrEn_SI) mem_we = 1'b1;
          else         rd_acc = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign Ready_SO = (state_q == READY);

  always_ff @(posedge Clk_CI) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Stage p0: array read; data only updates on an accepted read so it holds otherwise.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) rd_data_p0 <= mem[Addr_DI];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // Stage p1: optional output register.
      always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_data_p1 <= rd_data_p0;
        end
      end

      assign RdData_DO  = rd_data_p1;
      assign RdValid_SO = vld_p1;
    end else begin : g_no_out_reg
      assign RdData_DO  = rd_data_p0;
      assign RdValid_SO = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_sync_sp_ram_be_init.sv
// Directed bench for sync_sp_ram_be_init: one instance without and one with the
// output register, sharing the same stimulus.
module tb_sync_sp_ram_be_init;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        cs;
  logic        we;
  logic [7:0]  be;
  logic [7:0]  addr;
  logic [63:0] wdata;

  logic        ready0, ready1;
  logic [63:0] rd_data0, rd_data1;
  logic        rd_vld0, rd_vld1;

  int tests = 0;
  int fails = 0;

  sync_sp_ram_be_init #(.DATA_WIDTH(64), .DEPTH(256), .OUT_REG(1'b0)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Init_SI(init), .Ready_SO(ready0),
    .CSel_SI(cs), .WrEn_SI(we), .BEn_SI(be), .Addr_DI(addr), .WrData_DI(wdata),
    .RdData_DO(rd_data0), .RdValid_SO(rd_vld0)
  );

  sync_sp_ram_be_init #(.DATA_WIDTH(64), .DEPTH(256), .OUT_REG(1'b1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Init_SI(init), .Ready_SO(ready1),
    .CSel_SI(cs), .WrEn_SI(we), .BEn_SI(be), .Addr_DI(addr), .WrData_DI(wdata),
    .RdData_DO(rd_data1), .RdValid_SO(rd_vld1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [7:0] b,
                       input logic [7:0] a, input logic [63:0] d);
    cs    = c;
    we    = w;
    be    = b;
    addr  = a;
    wdata = d;
  endtask

  // Runs exactly 256 edges of fill; Ready must stay low until the 256th edge.
  task automatic fill_check(input string tag, input bit pulse_cs);
    int early;
    int vld_seen;
    early    = 0;
    vld_seen = 0;
    for (int k = 1; k <= 256; k++) begin
      drive(pulse_cs && (k < 250) && k[0], 1'b0, 8'h00, 8'(k), 64'h0);
      step();
      if (k < 256 && (ready0 !== 1'b0 || ready1 !== 1'b0)) early++;
      if (rd_vld0 !== 1'b0 || rd_vld1 !== 1'b0) vld_seen++;
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    check({tag, "_ready_early"}, 64'(early), 64'd0);
    check({tag, "_vld_during_init"}, 64'(vld_seen), 64'd0);
    check({tag, "_ready0_at_257"}, 64'(ready0), 64'd1);
    check({tag, "_ready1_at_257"}, 64'(ready1), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);

    // Reset state
    step();
    step();
    check("rst_ready0", 64'(ready0), 64'd0);
    check("rst_vld0", 64'(rd_vld0), 64'd0);
    check("rst_data0", rd_data0, 64'h0);
    check("rst_vld1", 64'(rd_vld1), 64'd0);
    check("rst_data1", rd_data1, 64'h0);

    // Fill after reset release, with CSel pulses that must be ignored
    rst_n = 1'b1;
    fill_check("fill1", 1'b1);

    // Reads of first and last address after fill
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("rd00_vld0", 64'(rd_vld0), 64'd1);
    check("rd00_data0", rd_data0, 64'h0);
    drive(1'b1, 1'b0, 8'h00, 8'hFF, 64'h0);
    step();
    check("rdFF_vld0", 64'(rd_vld0), 64'd1);
    check("rdFF_data0", rd_data0, 64'h0);
    check("rd00_vld1", 64'(rd_vld1), 64'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    step();
    check("idle_vld0", 64'(rd_vld0), 64'd0);
    check("rdFF_vld1", 64'(rd_vld1), 64'd1);
    check("rdFF_data1", rd_data1, 64'h0);

    // Byte-enable merge at 0x10
    drive(1'b1, 1'b1, 8'hFF, 8'h10, 64'h1122_3344_5566_7788);
    step();
    check("wr_no_vld0", 64'(rd_vld0), 64'd0);
    check("wr_data_hold0", rd_data0, 64'h0);
    drive(1'b1, 1'b1, 8'h0F, 8'h10, 64'hAAAA_AAAA_AAAA_AAAA);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h10, 64'h0);
    step();
    check("be_vld0", 64'(rd_vld0), 64'd1);
    check("be_data0", rd_data0, 64'h1122_3344_AAAA_AAAA);
    check("be_vld1_early", 64'(rd_vld1), 64'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    step();
    check("be_vld1", 64'(rd_vld1), 64'd1);
    check("be_data1", rd_data1, 64'h1122_3344_AAAA_AAAA);
    check("be_hold0", rd_data0, 64'h1122_3344_AAAA_AAAA);

    // Back-to-back reads through the output register
    drive(1'b1, 1'b1, 8'hFF, 8'h01, 64'h1);
    step();
    drive(1'b1, 1'b1, 8'hFF, 8'h02, 64'h2);
    step();
    drive(1'b1, 1'b1, 8'hFF, 8'h03, 64'h3);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h01, 64'h0);
    step();
    check("pipe_acc1_vld1", 64'(rd_vld1), 64'd0);
    check("pipe_acc1_data0", rd_data0, 64'h1);
    drive(1'b1, 1'b0, 8'h00, 8'h02, 64'h0);
    step();
    check("pipe_a2_vld1", 64'(rd_vld1), 64'd1);
    check("pipe_a2_data1", rd_data1, 64'h1);
    drive(1'b1, 1'b0, 8'h00, 8'h03, 64'h0);
    step();
    check("pipe_a3_vld1", 64'(rd_vld1), 64'd1);
    check("pipe_a3_data1", rd_data1, 64'h2);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    step();
    check("pipe_a4_vld1", 64'(rd_vld1), 64'd1);
    check("pipe_a4_data1", rd_data1, 64'h3);
    step();
    check("pipe_after_vld1", 64'(rd_vld1), 64'd0);
    check("pipe_after_data1", rd_data1, 64'h3);

    // Write then immediate read; zero byte-enable write is a no-op
    drive(1'b1, 1'b1, 8'hFF, 8'h05, 64'hDEAD);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h05, 64'h0);
    step();
    check("raw_vld0", 64'(rd_vld0), 64'd1);
    check("raw_data0", rd_data0, 64'hDEAD);
    drive(1'b1, 1'b1, 8'h00, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h05, 64'h0);
    step();
    check("be0_data0", rd_data0, 64'hDEAD);

    // Read accepted right before Init, with a dropped same-cycle access
    drive(1'b1, 1'b1, 8'hFF, 8'hC8, 64'h1234);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h05, 64'h0);
    step();
    check("preinit_data0", rd_data0, 64'hDEAD);
    drive(1'b1, 1'b0, 8'h00, 8'h10, 64'h0);
    init = 1'b1;
    step();
    init = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    check("init_ready_drop", 64'(ready0), 64'd0);
    check("init_drop_vld0", 64'(rd_vld0), 64'd0);
    check("init_hold_data0", rd_data0, 64'hDEAD);
    check("init_pre_vld1", 64'(rd_vld1), 64'd1);
    check("init_pre_data1", rd_data1, 64'hDEAD);
    fill_check("fill2", 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h05, 64'h0);
    step();
    check("postinit_vld0", 64'(rd_vld0), 64'd1);
    check("postinit_data0", rd_data0, 64'h0);

    // Reset in the middle of a fill
    drive(1'b1, 1'b1, 8'hFF, 8'h07, 64'h77);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h07, 64'h0);
    step();
    check("rd7_data0", rd_data0, 64'h77);
    drive(1'b1, 1'b1, 8'hFF, 8'hC8, 64'h1234);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    init = 1'b1;
    step();
    init = 1'b0;
    for (int k = 0; k < 100; k++) step();
    check("init_keeps_data0", rd_data0, 64'h77);
    rst_n = 1'b0;
    #1;
    check("midrst_data0", rd_data0, 64'h0);
    check("midrst_data1", rd_data1, 64'h0);
    check("midrst_ready0", 64'(ready0), 64'd0);
    step();
    step();
    check("midrst_hold_data0", rd_data0, 64'h0);
    rst_n = 1'b1;
    fill_check("fill3", 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'hC8, 64'h0);
    step();
    check("fill3_c8_data0", rd_data0, 64'h0);
    drive(1'b1, 1'b0, 8'h00, 8'h07, 64'h0);
    step();
    check("fill3_07_data0", rd_data0, 64'h0);
    check("fill3_c8_data1", rd_data1, 64'h0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
